// File: rtl/eda_push_serializer.sv
// Expands a 3x3 neighbour push mask around a centre pixel into linear addresses
// and serialises them, lowest bit first, into a first-word-fall-through FIFO.
module eda_push_serializer #(
    parameter int M          = 16,
    parameter int N          = 16,
    parameter int ADDR_WIDTH = $clog2(M*N),
    parameter int I_WIDTH    = $clog2(M),
    parameter int J_WIDTH    = $clog2(N),
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          new_pixel,
    input  logic [I_WIDTH-1:0]            center_i,
    input  logic [J_WIDTH-1:0]            center_j,
    input  logic [7:0]                    push_positions,
    input  logic                          pop,
    output logic [ADDR_WIDTH-1:0]         fifo_dout,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    iterated_idx,
    output logic                          busy,
    output logic                          drop_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, DRAIN, STALL} state_t;

    state_t                state_q, state_d;
    logic [I_WIDTH-1:0]    ci_q, ci_d;
    logic [J_WIDTH-1:0]    cj_q, cj_d;
    logic [7:0]            pending_q, pending_d;
    logic [7:0]            iter_q, iter_d;
    logic                  drop_q, drop_d;
    logic [PTR_W-1:0]      wptr_q, rptr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [ADDR_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic                  wr_en, rd_en;
    logic [2:0]            sel_k;
    logic [7:0]            wr_mask;
    logic [3:0]            pos;
    logic [ADDR_WIDTH-1:0] row_a, col_a, wr_addr;

    // A write never happens on a new_pixel cycle: the old pending work is being discarded.
    assign wr_en = !new_pixel && ((state_q == DRAIN) || (state_q == STALL && pop));
    assign rd_en = pop && (count_q != '0);

    always_comb begin
        sel_k = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (pending_q[k]) sel_k = 3'(k);
        end
    end

    assign wr_mask = wr_en ? (8'b1 << sel_k) : 8'h00;

    // Window position skips the centre (p4); row/col offsets are p/3-1 and p%3-1.
    assign pos     = (sel_k < 3'd4) ? {1'b0, sel_k} : ({1'b0, sel_k} + 4'd1);
    assign row_a   = ADDR_WIDTH'(ci_q) + ADDR_WIDTH'(pos / 4'd3) - ADDR_WIDTH'(1);
    assign col_a   = ADDR_WIDTH'(cj_q) + ADDR_WIDTH'(pos % 4'd3) - ADDR_WIDTH'(1);
    assign wr_addr = row_a * ADDR_WIDTH'(N) + col_a;

    always_comb begin
        ci_d      = ci_q;
        cj_d      = cj_q;
        iter_d    = iter_q | wr_mask;
        pending_d = (pending_q & ~wr_mask) | (push_positions & ~(iter_q | wr_mask));
        drop_d    = drop_q;
        if (new_pixel) begin
            ci_d      = center_i;
            cj_d      = center_j;
            iter_d    = 8'h00;
            pending_d = push_positions;
            drop_d    = drop_q | (pending_q != 8'h00);
        end
        count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        if (pending_d == 8'h00)
            state_d = IDLE;
        else if (count_d == CNT_W'(FIFO_DEPTH))
            state_d = STALL;
        else
            state_d = DRAIN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ci_q      <= '0;
            cj_q      <= '0;
            pending_q <= 8'h00;
            iter_q    <= 8'h00;
            drop_q    <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            ci_q      <= ci_d;
            cj_q      <= cj_d;
            pending_q <= pending_d;
            iter_q    <= iter_d;
            drop_q    <= drop_d;
            count_q   <= count_d;
            if (wr_en) wptr_q <= wptr_q + PTR_W'(1);
            if (rd_en) rptr_q <= rptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q] <= wr_addr;
    end

    assign fifo_dout    = mem_q[rptr_q];
    assign fifo_empty   = (count_q == '0);
    assign fifo_full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_count   = count_q;
    assign iterated_idx = iter_q;
    assign busy         = (pending_q != 8'h00);
    assign drop_err     = drop_q;

endmodule

// File: tb/tb_eda_push_serializer.sv
// Directed bench for eda_push_serializer with a scoreboard of expected FIFO entries.
module tb_eda_push_serializer;

    localparam int M = 16, N = 16, AW = 8, DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          new_pixel = 1'b0;
    logic [3:0]    center_i = '0;
    logic [3:0]    center_j = '0;
    logic [7:0]    push_positions = '0;
    logic          pop = 1'b0;
    logic [AW-1:0] fifo_dout;
    logic          fifo_empty, fifo_full;
    logic [2:0]    fifo_count;
    logic [7:0]    iterated_idx;
    logic          busy, drop_err;

    int errors = 0;
    int checks = 0;
    int sb[$];

    eda_push_serializer #(.M(M), .N(N), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .new_pixel(new_pixel),
        .center_i(center_i), .center_j(center_j),
        .push_positions(push_positions), .pop(pop),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .fifo_count(fifo_count), .iterated_idx(iterated_idx),
        .busy(busy), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Independent address model: window offsets listed explicitly.
    function automatic int exp_addr(input int ci, input int cj, input int k);
        int dr[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
        int dc[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
        return (((ci + dr[k]) * N + (cj + dc[k])) & ((1 << AW) - 1));
    endfunction

    task automatic expect_mask(input int ci, input int cj, input logic [7:0] m);
        for (int k = 0; k < 8; k++) if (m[k]) sb.push_back(exp_addr(ci, cj, k));
    endtask

    task automatic start_pixel(input int ci, input int cj, input logic [7:0] m);
        new_pixel = 1'b1;
        center_i = 4'(ci);
        center_j = 4'(cj);
        push_positions = m;
        step();
        new_pixel = 1'b0;
        push_positions = 8'h00;
    endtask

    task automatic pop_check(input string tag);
        int e;
        e = (sb.size() != 0) ? sb.pop_front() : -1;
        chk(tag, 32'(fifo_dout), 32'(e));
        pop = 1'b1;
        step();
        pop = 1'b0;
    endtask

    initial begin
        // Reset state, no clock edge yet
        #1;
        chk("rst_empty", 32'(fifo_empty), 1);
        chk("rst_full", 32'(fifo_full), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_iter", 32'(iterated_idx), 0);
        chk("rst_drop", 32'(drop_err), 0);
        step();
        reset = 1'b0;
        step();

        // Ordering: centre (5,7), mask 0x81 -> 70 then 104
        start_pixel(5, 7, 8'h00);
        push_positions = 8'h81;
        expect_mask(5, 7, 8'h81);
        step();
        push_positions = 8'h00;
        chk("ord_busy_t1", 32'(busy), 1);
        chk("ord_empty_t1", 32'(fifo_empty), 1);
        step();
        chk("ord_count1", 32'(fifo_count), 1);
        chk("ord_empty_t2", 32'(fifo_empty), 0);
        chk("ord_iter1", 32'(iterated_idx), 32'h01);
        step();
        chk("ord_count2", 32'(fifo_count), 2);
        chk("ord_iter2", 32'(iterated_idx), 32'h81);
        chk("ord_busy_end", 32'(busy), 0);
        pop_check("ord_e0");
        pop_check("ord_e1");
        chk("ord_drained", 32'(fifo_empty), 1);

        // Full stall: prefill 4 entries, then mask 0x0F around (8,8)
        start_pixel(2, 3, 8'h0F);
        expect_mask(2, 3, 8'h0F);
        for (int i = 0; i < 4; i++) step();
        chk("stl_full", 32'(fifo_full), 1);
        chk("stl_prefill_busy", 32'(busy), 0);
        start_pixel(8, 8, 8'h00);
        push_positions = 8'h0F;
        expect_mask(8, 8, 8'h0F);
        step();
        push_positions = 8'h00;
        step();
        step();
        chk("stl_count_hold", 32'(fifo_count), 4);
        chk("stl_iter_hold", 32'(iterated_idx), 0);
        chk("stl_busy", 32'(busy), 1);
        chk("stl_head", 32'(fifo_dout), 32'(sb[0]));
        for (int i = 0; i < 4; i++) begin
            logic [7:0] want;
            want = 8'((1 << (i + 1)) - 1);
            pop_check($sformatf("stl_pop%0d", i));
            step();
            chk($sformatf("stl_count_p%0d", i), 32'(fifo_count), 4);
            chk($sformatf("stl_iter_p%0d", i), 32'(iterated_idx), 32'(want));
        end
        chk("stl_busy_done", 32'(busy), 0);

        // No re-push of an already enqueued bit
        push_positions = 8'h08;
        step();
        push_positions = 8'h00;
        step();
        step();
        chk("nrp_count", 32'(fifo_count), 4);
        chk("nrp_busy", 32'(busy), 0);
        chk("nrp_iter", 32'(iterated_idx), 32'h0F);
        for (int i = 0; i < 4; i++) pop_check($sformatf("nrp_e%0d", i));
        chk("nrp_empty", 32'(fifo_empty), 1);
        chk("nrp_drop", 32'(drop_err), 0);

        // Drop: mask 0xFF, new_pixel two cycles later
        start_pixel(3, 3, 8'h00);
        push_positions = 8'hFF;
        sb.push_back(exp_addr(3, 3, 0));
        step();
        push_positions = 8'h00;
        step();
        start_pixel(3, 3, 8'h00);
        step();
        chk("drp_err", 32'(drop_err), 1);
        chk("drp_iter", 32'(iterated_idx), 0);
        chk("drp_busy", 32'(busy), 0);
        chk("drp_cnt_le2", 32'(fifo_count <= 3'd2), 1);
        chk("drp_cnt_ge1", 32'(fifo_count >= 3'd1), 1);
        pop_check("drp_e0");
        for (int i = 0; i < 4 && !fifo_empty; i++) begin
            pop = 1'b1;
            step();
            pop = 1'b0;
        end
        chk("drp_empty", 32'(fifo_empty), 1);

        // Reset mid-drain: 3 queued, 4 pending
        start_pixel(5, 5, 8'h00);
        push_positions = 8'h7F;
        step();
        push_positions = 8'h00;
        step();
        step();
        step();
        chk("rmd_count3", 32'(fifo_count), 3);
        chk("rmd_busy_pre", 32'(busy), 1);
        chk("rmd_iter_pre", 32'(iterated_idx), 32'h07);
        reset = 1'b1;
        #1;
        chk("rmd_empty", 32'(fifo_empty), 1);
        chk("rmd_count0", 32'(fifo_count), 0);
        chk("rmd_busy", 32'(busy), 0);
        chk("rmd_iter", 32'(iterated_idx), 0);
        chk("rmd_drop", 32'(drop_err), 0);
        step();
        reset = 1'b0;
        pop = 1'b1;
        step();
        pop = 1'b0;
        chk("rmd_pop_empty", 32'(fifo_count), 0);
        step();
        step();
        chk("rmd_no_resume", 32'(fifo_count), 0);
        chk("rmd_still_empty", 32'(fifo_empty), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eda_push_serializer.md
EDA_PUSH_SERIALIZER -- requirements
Module: eda_push_serializer

Interface
REQ-001 The block SHALL have parameter M, default 16: image row count.
REQ-002 The block SHALL have parameter N, default 16: image column count.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default $clog2(M*N): linear pixel address width.
REQ-004 The block SHALL have parameters I_WIDTH, default $clog2(M), and J_WIDTH, default $clog2(N): row and column index widths.
REQ-005 The block SHALL have parameter FIFO_DEPTH, default 16: queue entries, power of 2, minimum 2.
REQ-006 Port clk, input, 1 bit: the single clock, rising edge.
REQ-007 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port new_pixel, input, 1 bit: one-cycle strobe that starts a new centre pixel.
REQ-009 Ports center_i (input, I_WIDTH) and center_j (input, J_WIDTH): centre row and column, sampled on new_pixel.
REQ-010 Port push_positions, input, 8 bits: one-cycle neighbour push mask from the compare stage.
REQ-011 Port pop, input, 1 bit: reader consumes the FIFO head.
REQ-012 Port fifo_dout, output, ADDR_WIDTH: head entry, first-word-fall-through.
REQ-013 Ports fifo_empty and fifo_full, outputs, 1 bit each: FIFO status flags.
REQ-014 Port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: current occupancy.
REQ-015 Port iterated_idx, output, 8 bits: neighbours already enqueued for the current centre (fed back to the compare stage).
REQ-016 Port busy, output, 1 bit: pending-mask nonzero.
REQ-017 Port drop_err, output, 1 bit: sticky flag set on pending work discarded by new_pixel.

Function
REQ-018 Neighbour bit k SHALL map to window position p = k for k<4 and p = k+1 for k>=4 (3x3 row-major, centre = p4).
REQ-019 The offsets (drow,dcol) for p = 0,1,2,3,5,6,7,8 SHALL be (-1,-1), (-1,0), (-1,+1), (0,-1), (0,+1), (+1,-1), (+1,0), (+1,+1).
REQ-020 The enqueued address SHALL be (ci+drow)*N + (cj+dcol), computed at ADDR_WIDTH with no bounds checking (upstream masks invalid neighbours).
REQ-021 On new_pixel, ci/cj SHALL load from center_i/center_j, and the pending mask and iterated_idx SHALL clear.
REQ-022 On each edge, the pending mask SHALL take pending | (push_positions & ~iterated_idx); on a cycle with new_pixel, the new pending mask SHALL be push_positions alone.
REQ-023 The FSM SHALL have three states: IDLE (pending==0), DRAIN (pending!=0 and a write is possible) and STALL (pending!=0 and fifo_full with no pop).
REQ-024 Transitions: IDLE->DRAIN on nonzero pending load; DRAIN->STALL on full without pop; STALL->DRAIN on pop; DRAIN->IDLE after the last bit is written; any state->IDLE on new_pixel with empty push_positions.
REQ-025 In DRAIN, one entry per cycle SHALL be written: the lowest set pending bit, which is then cleared in pending and set in iterated_idx.
REQ-026 Latency: push_positions asserted in cycle t SHALL produce its first write at the end of t+1, with fifo_empty low from t+2.
REQ-027 If new_pixel arrives while pending!=0, the old pending bits SHALL be discarded and drop_err SHALL set; drop_err clears only on reset.
REQ-028 FIFO behaviour:
- pop when empty: ignored;
- write when full and no pop: does not occur (STALL);
- simultaneous pop and write when full: allowed, count unchanged;
- read and write pointers wrap modulo FIFO_DEPTH.
REQ-029 fifo_dout SHALL present the head entry combinationally; its value when empty is don't-care.
REQ-030 busy SHALL equal (pending != 0).

Reset
REQ-031 While reset is high, all of the following SHALL hold immediately, independent of clk:
- pointers, fifo_count, pending, iterated_idx, ci, cj and drop_err cleared to 0;
- FSM in IDLE;
- fifo_empty=1, fifo_full=0, busy=0.
REQ-032 Reset asserted mid-DRAIN SHALL discard all pending and queued entries; no write SHALL occur on the reset edge.

Verification
REQ-033 Ordering: M=N=16, new_pixel with (5,7), then push_positions=8'b1000_0001 -> entries 70 then 104 written on consecutive cycles, iterated_idx=8'h81, busy low after the second write.
REQ-034 Full stall: FIFO_DEPTH=4, queue prefilled with 4 entries, push_positions=8'h0F -> FSM in STALL with no writes; each pop admits exactly one new entry, in bit order 0,1,2,3.
REQ-035 No re-push: after bit 3 has been enqueued, push_positions=8'h08 again -> no new entry, fifo_count unchanged.
REQ-036 Drop: push_positions=8'hFF, then new_pixel two cycles later -> at most 2 entries written, drop_err=1, iterated_idx=0.
REQ-037 Reset mid-drain: reset pulsed with 3 queued and 4 pending -> fifo_empty=1, fifo_count=0, busy=0 immediately; pop on the empty FIFO is ignored with count staying 0.
